// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: RISC-V field positions,
// the canonical NOP encoding and the fetch FSM state constants.
package instr_fetch_pkg;

    localparam int unsigned OpcodeLo = 0;
    localparam int unsigned OpcodeHi = 6;
    localparam int unsigned RdLo     = 7;
    localparam int unsigned RdHi     = 11;
    localparam int unsigned Rs1Lo    = 15;
    localparam int unsigned Rs1Hi    = 19;
    localparam int unsigned Rs2Lo    = 20;
    localparam int unsigned Rs2Hi    = 24;

    // addi x0, x0, 0
    localparam logic [31:0] InstrNop = 32'h0000_0013;

    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t StRun   = 1'b0;
    localparam fetch_state_t StStall = 1'b1;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding a fetched word and its PC while decode stalls.
// Flush wins over load, load wins over unload.
module fetch_skid_buf
    import instr_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        unload_i,
    input  logic [31:0] data_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic [31:0] pc_o
);

    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            pc_d    = pc_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= InstrNop;
            pc_q    <= 32'h0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// PC sequencer and fetch front end: one instruction per cycle from a registered
// instruction memory, stall absorption via a skid entry, redirect squashing.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        misalign_err
);

    localparam logic [31:0] AddrMask = 32'(IMEM_BYTES - 32'd1);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         req_valid_q, req_valid_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         inst_valid_q, inst_valid_d;
    logic         misalign_q, misalign_d;

    logic         skid_load, skid_flush, skid_unload;
    logic         skid_valid;
    logic [31:0]  skid_data, skid_pc;

    logic [31:0]  pc_next, redirect_target;

    assign pc_next         = (pc_q + 32'd4) & AddrMask;
    assign redirect_target = {redirect_pc[31:2], 2'b00} & AddrMask;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        req_valid_d  = req_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        misalign_d   = 1'b0;
        skid_load    = 1'b0;
        skid_flush   = 1'b0;
        skid_unload  = 1'b0;

        if (redirect_valid) begin
            // Whatever the memory returns next belongs to the old path; req_valid=0 drops it.
            pc_d         = redirect_target;
            req_valid_d  = 1'b0;
            inst_valid_d = 1'b0;
            skid_flush   = 1'b1;
            state_d      = StRun;
            misalign_d   = |redirect_pc[1:0];
        end else if (state_q == StRun) begin
            if (!stall) begin
                inst_d       = imem_dout;
                inst_pc_d    = req_pc_q;
                inst_valid_d = req_valid_q;
                req_pc_d     = pc_q;
                req_valid_d  = 1'b1;
                pc_d         = pc_next;
            end else begin
                skid_load   = req_valid_q;
                req_valid_d = 1'b0;
                state_d     = StStall;
            end
        end else if (!stall) begin
            // Release: skid feeds decode while the held pc is refetched, so no bubble.
            inst_d       = skid_data;
            inst_pc_d    = skid_pc;
            inst_valid_d = skid_valid;
            skid_unload  = 1'b1;
            req_pc_d     = pc_q;
            req_valid_d  = 1'b1;
            pc_d         = pc_next;
            state_d      = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            req_pc_q     <= 32'h0;
            req_valid_q  <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= 32'h0;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            req_valid_q  <= req_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (skid_load),
        .flush_i  (skid_flush),
        .unload_i (skid_unload),
        .data_i   (imem_dout),
        .pc_i     (req_pc_q),
        .valid_o  (skid_valid),
        .data_o   (skid_data),
        .pc_o     (skid_pc)
    );

    assign imem_addr    = pc_q;
    assign inst_valid   = inst_valid_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign opcode       = inst_q[OpcodeHi:OpcodeLo];
    assign rd           = inst_q[RdHi:RdLo];
    assign rs1          = inst_q[Rs1Hi:Rs1Lo];
    assign rs2          = inst_q[Rs2Hi:Rs2Lo];
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized stall/redirect/reset
// traffic compared against a stream-level model of the delivered instruction sequence.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned IMEM_BYTES = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        misalign_err;

    int n_total = 0;
    int n_bad   = 0;

    instr_fetch #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'd0:   return 32'h0102_2083;
            32'd4:   return 32'h0011_0113;
            32'd8:   return 32'h0108_2023;
            32'd12:  return 32'h01ef_4f33;
            default: return 32'h0011_0113;
        endcase
    endfunction

    // Registered memory: data for the sampled address appears after the edge.
    always @(posedge clk) imem_dout <= mem_word(imem_addr);

    // Stream model: m_next is the next PC decode should see, m_pend the bubbles before it.
    int          m_pend;
    logic [31:0] m_next;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    logic        m_mis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = 1;
        m_next  = RESET_PC;
        m_valid = 1'b0;
        m_inst  = 32'h0;
        m_pc    = 32'h0;
        m_mis   = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic r, input logic [31:0] rp);
        m_mis = 1'b0;
        if (r) begin
            m_mis   = (rp % 4) != 0;
            m_valid = 1'b0;
            m_next  = (rp - (rp % 4)) % IMEM_BYTES;
            m_pend  = 1;
        end else if (!s) begin
            if (m_pend > 0) begin
                m_valid = 1'b0;
                m_pend--;
            end else begin
                m_valid = 1'b1;
                m_inst  = mem_word(m_next);
                m_pc    = m_next;
                m_next  = (m_next + 4) % IMEM_BYTES;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_addr;
        exp_addr = (m_pend > 0) ? m_next : (m_next + 4) % IMEM_BYTES;
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
        chk("imem_addr", imem_addr, exp_addr);
        if (m_valid) begin
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_pc);
            chk("opcode", {25'b0, opcode}, {25'b0, m_inst[6:0]});
            chk("rd", {27'b0, rd}, {27'b0, m_inst[11:7]});
            chk("rs1", {27'b0, rs1}, {27'b0, m_inst[19:15]});
            chk("rs2", {27'b0, rs2}, {27'b0, m_inst[24:20]});
        end
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rp);
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rp;
        @(posedge clk);
        model_edge(s, r, rp);
        #1;
        check_all();
    endtask

    task automatic run_until_pc(input logic [31:0] target);
        for (int i = 0; i < 80; i++) begin
            if (inst_valid && inst_pc == target) return;
            step(1'b0, 1'b0, 32'h0);
        end
        chk("run_until_pc_timeout", inst_pc, target);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'h0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        rst_n = 1'b1;

        // Reset release latency and field extraction
        step(1'b0, 1'b0, 32'h0);
        chk("e1_valid", {31'b0, inst_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("e2_inst", inst, 32'h0102_2083);
        chk("e2_pc", inst_pc, 32'd0);
        chk("e2_rd", {27'b0, rd}, 32'd1);
        chk("e2_rs1", {27'b0, rs1}, 32'd4);
        chk("e2_rs2", {27'b0, rs2}, 32'd16);
        step(1'b0, 1'b0, 32'h0);
        chk("e3_pc", inst_pc, 32'd4);
        step(1'b0, 1'b0, 32'h0);
        chk("e4_pc", inst_pc, 32'd8);
        step(1'b0, 1'b0, 32'h0);
        chk("e5_inst", inst, 32'h01ef_4f33);
        chk("e5_opcode", {25'b0, opcode}, 32'h33);
        chk("e5_rd", {27'b0, rd}, 32'd30);
        chk("e5_rs1", {27'b0, rs1}, 32'd30);
        chk("e5_rs2", {27'b0, rs2}, 32'd30);

        // Stall three cycles while pc 4 is presented
        step(1'b0, 1'b1, 32'd0);
        run_until_pc(32'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("stall_inst_hold", inst, 32'h0011_0113);
            chk("stall_pc_hold", inst_pc, 32'd4);
        end
        step(1'b0, 1'b0, 32'h0);
        chk("release_pc8", inst_pc, 32'd8);
        step(1'b0, 1'b0, 32'h0);
        chk("release_pc12", inst_pc, 32'd12);

        // Redirect to 12 while pc 4 is presented
        step(1'b0, 1'b1, 32'd0);
        run_until_pc(32'd4);
        step(1'b0, 1'b1, 32'd12);
        chk("redir_bubble0", {31'b0, inst_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("redir_bubble1", {31'b0, inst_valid}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("redir_inst", inst, 32'h01ef_4f33);
        chk("redir_pc", inst_pc, 32'd12);

        // Wrap at the top of instruction memory
        step(1'b0, 1'b1, 32'd248);
        run_until_pc(32'd248);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_252", inst_pc, 32'd252);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_0", inst_pc, 32'd0);
        chk("wrap_0_inst", inst, 32'h0102_2083);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_4", inst_pc, 32'd4);

        // Misaligned redirect coinciding with stall
        step(1'b1, 1'b1, 32'h0000_000A);
        chk("mis_pulse", {31'b0, misalign_err}, 32'h1);
        step(1'b0, 1'b0, 32'h0);
        chk("mis_clear", {31'b0, misalign_err}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("mis_resume_pc", inst_pc, 32'd8);
        chk("mis_resume_valid", {31'b0, inst_valid}, 32'h1);

        // Asynchronous reset during a stall
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", {31'b0, inst_valid}, 32'h0);
        chk("arst_addr", imem_addr, RESET_PC);
        stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("arst_refetch_pc", inst_pc, RESET_PC);
        chk("arst_refetch_valid", {31'b0, inst_valid}, 32'h1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        s;
            logic        r;
            logic [31:0] rp;
            s  = ($urandom_range(99) < 30);
            r  = ($urandom_range(99) < 7);
            rp = $urandom;
            if ($urandom_range(299) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                chk("rand_arst_valid", {31'b0, inst_valid}, 32'h0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            step(s, r, rp);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
